// File: rtl/fb_hazardctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, EX-resolved branch flushes
// and data-memory busy holds, driving the PC, IF/ID and ID/EX control inputs.
module fb_hazardctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_valid,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_lock,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT} state_e;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic             ret_q, ret_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [6:0] opcode;
  logic       rs1_used, rs2_used, ldu;
  logic       pc_we_c, lock_c, flush_c, bubble_c, hold_c;
  logic       unused_bits;

  assign opcode   = id_inst[6:0];
  assign rs1_used = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign rs2_used = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign ldu = ex_valid && ex_memread && (ex_rd != 5'd0) &&
               ((rs1_used && (id_inst[19:15] == ex_rd)) ||
                (rs2_used && (id_inst[24:20] == ex_rd)));
  assign unused_bits = ^{id_inst[31:25], id_inst[14:7]};

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    ret_d    = ret_q;
    pc_we_c  = imem_ready;
    lock_c   = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    hold_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          pc_we_c = 1'b0;
          lock_c  = 1'b1;
          hold_c  = 1'b1;
          state_d = MEMWAIT;
          ret_d   = 1'b0;
        end else if (branch_taken) begin
          pc_we_c  = 1'b1;
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (MULTI_FLUSH) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_RELOAD;
          end
        end else if (ldu) begin
          // One-cycle stall: the load leaves EX on this edge, clearing ldu.
          pc_we_c  = 1'b0;
          lock_c   = 1'b1;
          bubble_c = 1'b1;
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          pc_we_c = 1'b0;
          lock_c  = 1'b1;
          hold_c  = 1'b1;
          state_d = MEMWAIT;
          ret_d   = 1'b1;
        end else begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (branch_taken) begin
            pc_we_c = 1'b1;
            fcnt_d  = FLUSH_RELOAD;
          end else if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end
      MEMWAIT: begin
        // EX is frozen here, so branch/ldu are re-presented after exit.
        pc_we_c = 1'b0;
        lock_c  = 1'b1;
        hold_c  = 1'b1;
        if (!mem_busy) begin
          state_d = ret_q ? FLUSH : RUN;
          ret_d   = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 3'd0;
        ret_d   = 1'b0;
      end
    endcase
  end

  assign pc_we       = rst_n & pc_we_c;
  assign ifid_we     = rst_n & imem_ready & (state_q != MEMWAIT);
  assign ifid_lock   = ~rst_n | lock_c;
  assign ifid_flush  = rst_n & flush_c;
  assign idex_bubble = rst_n & bubble_c;
  assign pipe_hold   = ~rst_n | hold_c;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      ret_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ret_q   <= ret_d;
      if (!pc_we_c && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule
